// File: rtl/led_pio_arbiter_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
//   state_t        : arbiter FSM states
//   PIO_ADDR_DATA  : PIO register address mirrored by the shadow copy
//   DW_DEFAULT     : default data width (PIO data register width)
//   AW_DEFAULT     : default PIO address width
package led_pio_pkg;

  localparam int unsigned DW_DEFAULT    = 32;
  localparam int unsigned AW_DEFAULT    = 2;
  localparam int unsigned PIO_ADDR_DATA = 0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/led_pio_arbiter_if.sv
// Bundle of the two requester handshakes and the Avalon-MM PIO slave port.
//   master modport : arbiter view (drives acks, PIO bus, shadow, busy)
//   slave modport  : environment view (drives requests, observes the rest)
// Requester n: reqn/addrn/wdatan in, ackn out (one-cycle completion pulse).
// PIO: pio_chipselect, pio_write_n (active low), pio_address, pio_writedata.
// shadow: last data written to the PIO data register; busy: FSM not idle.
interface led_pio_arbiter_if
  import led_pio_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) ();

  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic          pio_chipselect;
  logic          pio_write_n;
  logic [AW-1:0] pio_address;
  logic [DW-1:0] pio_writedata;
  logic [DW-1:0] shadow;
  logic          busy;

  modport master (
    input  req0, addr0, wdata0, req1, addr1, wdata1,
    output ack0, ack1, pio_chipselect, pio_write_n, pio_address,
           pio_writedata, shadow, busy
  );

  modport slave (
    output req0, addr0, wdata0, req1, addr1, wdata1,
    input  ack0, ack1, pio_chipselect, pio_write_n, pio_address,
           pio_writedata, shadow, busy
  );

endinterface

// File: rtl/led_pio_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_i        : pending requests, bit n = requester n
//   last_grant_i : index granted most recently
//   valid_o      : at least one request pending
//   grant_o      : index to grant; on a tie the one not granted last wins
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Two-requester write arbiter in front of the LED PIO Avalon-MM slave.
// Each grant issues one single-cycle write, then a one-cycle ack to the
// granted requester. A shadow of the PIO data register is kept for
// read-modify-write without bus reads.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : requester handshakes, PIO bus, shadow and busy (master side)
module led_pio_arbiter
  import led_pio_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  led_pio_arbiter_if.master  bus
);

  state_t        state_q;
  logic          grant_q;
  logic          last_grant_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          cs_q;
  logic          write_n_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] shadow_q;
  logic          busy_q;

  logic          pick_valid_d;
  logic          pick_idx_d;

  rr_pick2 u_pick (
    .req_i        ({bus.req1, bus.req0}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid_d),
    .grant_o      (pick_idx_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      shadow_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            grant_q   <= pick_idx_d;
            addr_q    <= pick_idx_d ? bus.addr1  : bus.addr0;
            data_q    <= pick_idx_d ? bus.wdata1 : bus.wdata0;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          if (addr_q == AW'(PIO_ADDR_DATA)) begin
            shadow_q <= data_q;
          end
          ack0_q    <= ~grant_q;
          ack1_q    <= grant_q;
          state_q   <= DONE;
        end
        DONE: begin
          // Requests are not sampled here, so a requester dropping req on
          // its ack edge is never granted twice.
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.pio_chipselect = cs_q;
  assign bus.pio_write_n    = write_n_q;
  assign bus.pio_address    = addr_q;
  assign bus.pio_writedata  = data_q;
  assign bus.shadow         = shadow_q;
  assign bus.busy           = busy_q;

endmodule
